ternary_matvec_unit: RTL and testbench
======================================

# ternary_matvec_unit

Sequential ternary matrix–vector multiplier: accepts a `ternary_matrix_t` W and a `vector_t` x, and returns y = W·x with saturating Q5.3 arithmetic. It processes one column per cycle across all D rows in parallel. It sits downstream of the weight and activation sources and upstream of the unary-operation stage. It is the executing end of the ternary/fixed-point operations defined in `config_pkg`.

## Interface
Parameters:
- `D`, default `config_pkg::D` (4): vector length and matrix dimension.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid_i`  in  1  operands valid.
- `in_ready_o`  out  1  unit can accept operands.
- `matrix_i`  in  `ternary_matrix_t`  W. `matrix_i[r][c]` is row r, column c.
- `vector_i`  in  `vector_t`  x, Q5.3 signed.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  downstream accepts the result.
- `result_o`  out  `vector_t`  y, held stable while `out_valid_o` is high.
- `illegal_o`  out  1  qualified by `out_valid_o`. High if any W entry was the code 2'b10.

## Operation
- FSM states:
  - IDLE: `in_ready_o`=1. On `in_valid_i`, latch W and x, clear all accumulators, clear the illegal flag, set column counter c=0, go to COMPUTE.
  - COMPUTE: each cycle, for every row r: acc[r] ← fixed_point_add(acc[r], ternary_mul(W[r][c]), x[c]). Then c++. After the cycle with c=D-1, go to DONE.
  - DONE: `out_valid_o`=1, `result_o`=acc. When `out_ready_i`=1, go to IDLE.
- Accumulation order is fixed: c = 0..D-1. Saturation happens at every step, not once at the end, so the result depends on order. Bit-exact to this sequence.
- Saturation bounds are FixedPointMax = 127 (15.875) and FixedPointMin = −128 (−16.0).
- Negating −128 for a −1 weight saturates to +127. It does not wrap.
- Code 2'b10 contributes 0 and sets the sticky illegal flag for the current operation.
- `in_ready_o` is low in COMPUTE and DONE. Operands presented then are ignored, not queued.
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `result_o`=0, `illegal_o`=0, FSM=IDLE, c=0, acc=0.
- Reset mid-operation: the operation is abandoned and no result is produced. Outputs take their reset values asynchronously.

## Timing
- Accept edge T: `in_valid_i` && `in_ready_o` sampled high.
- Columns 0..D-1 are processed on edges T+1..T+D.
- `out_valid_o` rises after edge T+D, so latency is D cycles from accept to valid.
- Output handshake completes at the first edge with `out_valid_o` && `out_ready_i`. `out_valid_o` falls after that edge and `in_ready_o` rises in the same cycle.
- There is no same-cycle bypass from DONE to accept. Minimum initiation interval is D+2 cycles.
- `result_o` and `illegal_o` are registered and change only on the transition into DONE or on reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Keep using the existing shared package items: `ternary_t`, `vector_t`, `ternary_matrix_t`, `fixed_point_t`, FixedPointMin/Max, `ternary_mul`, `fixed_point_add`.
- Add to `config_pkg`:
  - `matvec_state_t` enum {IDLE, COMPUTE, DONE}.
  - Localparam `TernaryIllegal` = 2'sb10.
  - `ternary_mul` is currently `unique case` returning 'x on the illegal code. Add a separate `ternary_is_legal` function, and have the unit compute the contribution itself so 2'b10 maps to 0 explicitly.
- One sub-module is natural: `ternary_mac_lane`. It holds one row accumulator with saturating add and is instantiated D times. Keep the FSM and counter in the top module.

## Test plan
- Identity W, x=[8,16,−8,0] (1.0, 2.0, −1.0, 0) -> y=[8,16,−8,0], `illegal_o`=0, `out_valid_o` exactly D=4 cycles after accept.
- W all −1, x=[8,8,8,8] -> y=[−32,−32,−32,−32].
- Order-dependent saturation: row [1,1,−1,−1], x=[100,100,100,0] -> y[r]=27. The row saturates to 127 at step 1, then 127−100=27. A bench computing the unsaturated sum (100) fails.
- Negative saturation and negation of −128:
  - row [1,1,0,0], x=[−128,−128,0,0] -> −128.
  - row [−1,0,0,0], x=[−128,0,0,0] -> 127.
- Illegal code at W[2][1]=2'b10 with other entries legal -> row 2 omits the column-1 term, `illegal_o`=1. Next clean operation -> `illegal_o`=0.
- Backpressure and reset:
  - Hold `out_ready_i`=0 for 5 cycles -> `result_o` stable and `in_ready_o`=0 throughout. Handshake on cycle 6 -> `in_ready_o`=1 the next cycle.
  - Assert `rst_ni`=0 mid-COMPUTE -> `out_valid_o` never rises and `in_ready_o`=1 after release.

Source files
------------

// File: rtl/config_pkg.sv
// Shared ternary / Q5.3 fixed-point types and arithmetic helpers.
// Weight codes: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = illegal.
package config_pkg;

  localparam int D = 4;

  typedef logic signed [1:0] ternary_t;
  typedef logic signed [7:0] fixed_point_t;
  typedef fixed_point_t [D-1:0] vector_t;
  typedef ternary_t [D-1:0][D-1:0] ternary_matrix_t;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} matvec_state_t;

  localparam fixed_point_t FixedPointMax  = 8'sd127;
  localparam fixed_point_t FixedPointMin  = -8'sd128;
  localparam ternary_t     TernaryIllegal = 2'sb10;

  function automatic logic ternary_is_legal(ternary_t w);
    return w != TernaryIllegal;
  endfunction

  // Negating the most negative value clamps rather than wrapping back to itself.
  function automatic fixed_point_t ternary_mul(ternary_t w, fixed_point_t x);
    fixed_point_t res;
    unique case (w)
      2'sb00:  res = '0;
      2'sb01:  res = x;
      2'sb11:  res = (x == FixedPointMin) ? FixedPointMax : -x;
      default: res = 'x;
    endcase
    return res;
  endfunction

  function automatic fixed_point_t fixed_point_add(fixed_point_t a, fixed_point_t b);
    logic signed [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum > 9'sd127) begin
      return FixedPointMax;
    end else if (sum < -9'sd128) begin
      return FixedPointMin;
    end else begin
      return fixed_point_t'(sum[7:0]);
    end
  endfunction

endpackage

// File: rtl/ternary_mac_lane.sv
// One row accumulator: adds the ternary-weighted activation each enabled cycle,
// saturating at every step.
module ternary_mac_lane
  import config_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         en_i,
  input  ternary_t     weight_i,
  input  fixed_point_t act_i,
  output fixed_point_t acc_next_o
);

  fixed_point_t acc_q;
  fixed_point_t acc_d;
  fixed_point_t contrib;

  // The illegal code is steered to zero here so ternary_mul never sees it on the used path.
  always_comb begin
    contrib = '0;
    if (ternary_is_legal(weight_i)) begin
      contrib = ternary_mul(weight_i, act_i);
    end
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = fixed_point_add(acc_q, contrib);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/ternary_matvec_unit.sv
// Sequential ternary matrix-vector multiplier: one column per cycle across all
// rows, saturating Q5.3 accumulation, registered valid/ready handshakes.
module ternary_matvec_unit
  import config_pkg::*;
#(
  parameter int D = config_pkg::D
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  ternary_matrix_t matrix_i,
  input  vector_t         vector_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output vector_t         result_o,
  output logic            illegal_o
);

  localparam int ColW = (D > 1) ? $clog2(D) : 1;

  matvec_state_t   state_q;
  logic [ColW-1:0] col_q;
  ternary_matrix_t w_q;
  vector_t         x_q;
  vector_t         result_q;
  logic            illegal_q;
  logic            illegal_out_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic    accept;
  logic    computing;
  logic    lastCol;
  logic    colIllegal;
  vector_t accNext;

  assign accept    = (state_q == IDLE) && in_valid_i;
  assign computing = (state_q == COMPUTE);
  assign lastCol   = (col_q == ColW'(D - 1));

  always_comb begin
    colIllegal = 1'b0;
    for (int r = 0; r < D; r++) begin
      if (!ternary_is_legal(w_q[r][col_q])) begin
        colIllegal = 1'b1;
      end
    end
  end

  for (genvar r = 0; r < D; r++) begin : g_lane
    ternary_mac_lane u_lane (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (accept),
      .en_i       (computing),
      .weight_i   (w_q[r][col_q]),
      .act_i      (x_q[col_q]),
      .acc_next_o (accNext[r])
    );
  end

  // The result captures the lane's next value so the last column is included on entry to DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      col_q         <= '0;
      w_q           <= '0;
      x_q           <= '0;
      result_q      <= '0;
      illegal_q     <= 1'b0;
      illegal_out_q <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            w_q        <= matrix_i;
            x_q        <= vector_i;
            illegal_q  <= 1'b0;
            col_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (colIllegal) begin
            illegal_q <= 1'b1;
          end
          if (lastCol) begin
            col_q         <= '0;
            result_q      <= accNext;
            illegal_out_q <= illegal_q | colIllegal;
            out_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign illegal_o   = illegal_out_q;

endmodule

// File: tb/tb_ternary_matvec_unit.sv
// Directed bench for ternary_matvec_unit: vector table plus backpressure,
// ignored-operand and mid-operation reset sequences.
module tb_ternary_matvec_unit;
  import config_pkg::*;

  typedef ternary_t [D-1:0] row_t;

  typedef struct {
    ternary_matrix_t w;
    vector_t         x;
    vector_t         y;
    logic            ill;
  } vec_rec_t;

  logic            clk;
  logic            rstN;
  logic            inValid;
  logic            inReady;
  ternary_matrix_t matrix;
  vector_t         vector;
  logic            outValid;
  logic            outReady;
  vector_t         result;
  logic            illegal;

  int assertCount = 0;
  int failCount   = 0;

  vec_rec_t tv[8];

  ternary_matvec_unit #(.D(D)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .matrix_i    (matrix),
    .vector_i    (vector),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .result_o    (result),
    .illegal_o   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ternary_t code(int v);
    case (v)
      1:       return 2'sb01;
      -1:      return 2'sb11;
      2:       return 2'sb10;
      default: return 2'sb00;
    endcase
  endfunction

  function automatic row_t row4(int a, int b, int c, int d);
    row_t r;
    r[0] = code(a);
    r[1] = code(b);
    r[2] = code(c);
    r[3] = code(d);
    return r;
  endfunction

  function automatic vector_t vec4(int a, int b, int c, int d);
    vector_t v;
    v[0] = fixed_point_t'(a);
    v[1] = fixed_point_t'(b);
    v[2] = fixed_point_t'(c);
    v[3] = fixed_point_t'(d);
    return v;
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input vector_t expY, input logic expIll);
    for (int r = 0; r < D; r++) begin
      checkVal($sformatf("%s result[%0d]", tag, r), int'(result[r]), int'(expY[r]));
    end
    checkVal({tag, " illegal"}, int'(illegal), int'(expIll));
  endtask

  // Drives one operation and waits for out_valid; returns the observed latency.
  task automatic applyStimulus(input string tag, input ternary_matrix_t w, input vector_t x,
                               output int latency);
    @(negedge clk);
    matrix  = w;
    vector  = x;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkVal({tag, " in_ready low after accept"}, int'(inReady), 0);
    latency = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      latency++;
      if (outValid) break;
    end
    checkVal({tag, " latency"}, latency, D);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkVal({tag, " out_valid falls"}, int'(outValid), 0);
    checkVal({tag, " in_ready rises"}, int'(inReady), 1);
  endtask

  initial begin
    int lat;
    logic sawValid;

    tv[0].w[0] = row4(1, 0, 0, 0);  tv[0].w[1] = row4(0, 1, 0, 0);
    tv[0].w[2] = row4(0, 0, 1, 0);  tv[0].w[3] = row4(0, 0, 0, 1);
    tv[0].x = vec4(8, 16, -8, 0);   tv[0].y = vec4(8, 16, -8, 0);   tv[0].ill = 1'b0;

    for (int r = 0; r < D; r++) tv[1].w[r] = row4(-1, -1, -1, -1);
    tv[1].x = vec4(8, 8, 8, 8);     tv[1].y = vec4(-32, -32, -32, -32); tv[1].ill = 1'b0;

    for (int r = 0; r < D; r++) tv[2].w[r] = row4(1, 1, -1, -1);
    tv[2].x = vec4(100, 100, 100, 0); tv[2].y = vec4(27, 27, 27, 27); tv[2].ill = 1'b0;

    tv[3].w[0] = row4(1, 1, 0, 0);  tv[3].w[1] = row4(-1, 0, 0, 0);
    tv[3].w[2] = row4(1, -1, 0, 0); tv[3].w[3] = row4(0, 0, 0, -1);
    tv[3].x = vec4(-128, -128, 0, 5); tv[3].y = vec4(-128, 127, -1, -5); tv[3].ill = 1'b0;

    for (int r = 0; r < D; r++) tv[4].w[r] = row4(1, 1, 1, 1);
    tv[4].w[2] = row4(1, 2, 1, 1);
    tv[4].x = vec4(1, 2, 4, 8);     tv[4].y = vec4(15, 15, 13, 15);  tv[4].ill = 1'b1;

    for (int r = 0; r < D; r++) tv[5].w[r] = row4(1, 1, 1, 1);
    tv[5].x = vec4(1, 2, 4, 8);     tv[5].y = vec4(15, 15, 15, 15);  tv[5].ill = 1'b0;

    tv[6].w[0] = row4(1, -1, 1, -1);   tv[6].w[1] = row4(0, 1, 0, 1);
    tv[6].w[2] = row4(-1, -1, -1, -1); tv[6].w[3] = row4(1, 1, 1, 1);
    tv[6].x = vec4(10, 20, 30, 40); tv[6].y = vec4(-20, 60, -100, 100); tv[6].ill = 1'b0;

    tv[7].w[0] = row4(1, 1, 1, -1);  tv[7].w[1] = row4(-1, -1, 0, 0);
    tv[7].w[2] = row4(-1, 1, 0, 0);  tv[7].w[3] = row4(0, 0, 1, 1);
    tv[7].x = vec4(120, 120, -50, 100); tv[7].y = vec4(-23, -128, 0, 50); tv[7].ill = 1'b0;

    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    matrix   = '0;
    vector   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset in_ready", int'(inReady), 1);
    checkVal("reset out_valid", int'(outValid), 0);
    checkVal("reset result[0]", int'(result[0]), 0);
    checkVal("reset result[3]", int'(result[3]), 0);
    checkVal("reset illegal", int'(illegal), 0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(tag, tv[i].w, tv[i].x, lat);
      checkOutput(tag, tv[i].y, tv[i].ill);
      handshake(tag);
    end

    // Backpressure: hold out_ready low while stray operands are offered.
    @(negedge clk);
    matrix  = tv[2].w;
    vector  = tv[2].x;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    matrix = tv[1].w;
    vector = tv[1].x;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (outValid) break;
    end
    checkVal("bp latency", lat, D);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp hold%0d", i), tv[2].y, 1'b0);
      checkVal($sformatf("bp hold%0d in_ready", i), int'(inReady), 0);
      checkVal($sformatf("bp hold%0d out_valid", i), int'(outValid), 1);
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    handshake("bp");

    // Reset in the middle of COMPUTE abandons the operation.
    @(negedge clk);
    matrix  = tv[6].w;
    vector  = tv[6].x;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkVal("midrst in_ready async", int'(inReady), 1);
    checkVal("midrst out_valid async", int'(outValid), 0);
    @(negedge clk);
    rstN = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 2 * D + 4; i++) begin
      @(posedge clk);
      #1;
      if (outValid) sawValid = 1'b1;
    end
    checkVal("midrst out_valid never rises", int'(sawValid), 0);
    checkVal("midrst in_ready after release", int'(inReady), 1);
    checkVal("midrst result cleared", int'(result[1]), 0);

    applyStimulus("post-reset", tv[3].w, tv[3].x, lat);
    checkOutput("post-reset", tv[3].y, tv[3].ill);
    handshake("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
